// File: rtl/cfi_lp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cfi_lp_ctrl
// Brief   : Forward-edge CFI landing-pad (Zicfilp) ELP tracker at commit.
// Revision: 1.0 - initial release
// ============================================================================
module cfi_lp_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lp_en_i,
    input  logic             commit_valid_i,
    input  logic [31:0]      commit_instr_i,
    input  logic             commit_compressed_i,
    input  logic [XLEN-1:0]  commit_pc_i,
    input  logic [XLEN-1:0]  x7_i,
    input  logic             trap_i,
    input  logic             xret_i,
    input  logic             xpelp_i,
    output logic             elp_o,
    output logic             sw_check_valid_o,
    output logic [XLEN-1:0]  sw_check_tval_o,
    output logic [CNT_W-1:0] viol_cnt_o
);

    typedef enum logic [0:0] {
        NO_LP_EXPECTED = 1'b0,
        LP_EXPECTED    = 1'b1
    } lp_state_t;

    localparam logic [6:0]      C_OP_JALR  = 7'b1100111;
    localparam logic [6:0]      C_OP_AUIPC = 7'b0010111;
    localparam logic [XLEN-1:0] C_TVAL_LP  = XLEN'(2);

    lp_state_t        r_state;
    lp_state_t        w_state_nxt;
    logic             w_viol;
    logic [CNT_W-1:0] r_viol_cnt;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rd;
    logic [19:0] w_label;
    logic        w_is_ind_jump;
    logic        w_is_lpad;
    logic        w_lpad_ok;

    assign w_opcode = commit_instr_i[6:0];
    assign w_rd     = commit_instr_i[11:7];
    assign w_rs1    = commit_instr_i[19:15];
    assign w_label  = commit_instr_i[31:12];

    // Jumps through x1/x5/x7 are returns or software-guarded calls; they never arm ELP.
    assign w_is_ind_jump = (w_opcode == C_OP_JALR) && (commit_instr_i[14:12] == 3'b000) &&
                           (w_rs1 != 5'd1) && (w_rs1 != 5'd5) && (w_rs1 != 5'd7);
    assign w_is_lpad     = (w_opcode == C_OP_AUIPC) && (w_rd == 5'd0) && !commit_compressed_i;
    assign w_lpad_ok     = w_is_lpad && (commit_pc_i[1:0] == 2'b00) &&
                           ((w_label == 20'd0) || (w_label == x7_i[31:12]));

    always_comb begin
        w_state_nxt = r_state;
        w_viol      = 1'b0;
        if (trap_i) begin
            w_state_nxt = NO_LP_EXPECTED;
        end else if (xret_i) begin
            w_state_nxt = xpelp_i ? LP_EXPECTED : NO_LP_EXPECTED;
        end else if (commit_valid_i) begin
            case (r_state)
                NO_LP_EXPECTED: begin
                    if (lp_en_i && w_is_ind_jump)
                        w_state_nxt = LP_EXPECTED;
                end
                LP_EXPECTED: begin
                    if (!lp_en_i)
                        w_state_nxt = NO_LP_EXPECTED;
                    else if (w_lpad_ok)
                        w_state_nxt = NO_LP_EXPECTED;
                    else
                        w_viol = 1'b1; // ELP held; the ensuing trap clears it
                end
                default: w_state_nxt = NO_LP_EXPECTED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= NO_LP_EXPECTED;
            r_viol_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_viol && (r_viol_cnt != {CNT_W{1'b1}}))
                r_viol_cnt <= r_viol_cnt + CNT_W'(1);
        end
    end

    assign elp_o            = (r_state == LP_EXPECTED);
    assign sw_check_valid_o = w_viol;
    assign sw_check_tval_o  = w_viol ? C_TVAL_LP : '0;
    assign viol_cnt_o       = r_viol_cnt;

    logic w_unused;
    assign w_unused = &{1'b0, commit_pc_i[XLEN-1:2], x7_i[XLEN-1:32], x7_i[11:0]};

endmodule
`default_nettype wire
